mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//  Shares one sequential 8x8 shift-add multiplier (4x4 core, start/done_flag, 16-bit d_out)
//  between NREQ requesters. Round-robin grant, latches operands, pulses the multiplier start,
//  waits for done, returns the 16-bit product to the owning requester. Watchdog aborts a
//  job that never completes. Sits between client blocks and the multiplier top.
// PARAMETERS
//  NREQ     2   number of requesters (2..8)
//  TIMEOUT  15  max cycles in WAIT before abort (>= 5; the multiplier needs 4)
//  IDW      3   width of owner id, >= clog2(NREQ)
// PORTS
//  clk        in   1        system clock, rising edge
//  rst        in   1        synchronous reset, active-high
//  req        in   NREQ     per-requester request level, held with operands until gnt
//  a_in       in   NREQ*8   operand A, requester i at [8i+7:8i]
//  b_in       in   NREQ*8   operand B, same packing
//  gnt        out  NREQ     one-hot 1-cycle accept pulse; operands captured that cycle
//  rsp_valid  out  NREQ     one-hot 1-cycle result pulse to the owner
//  rsp_err    out  1        with rsp_valid: job aborted by watchdog
//  rsp_data   out  16       product; held until the next response
//  busy       out  1        high in any state but IDLE
//  owner      out  IDW      id of current or last owner
//  mul_start  out  1        1-cycle start pulse to multiplier
//  mul_a      out  8        latched operand A, stable from ISSUE through WAIT
//  mul_b      out  8        latched operand B
//  mul_done   in   1        multiplier done_flag; sampled only in WAIT
//  mul_result in   16       multiplier d_out; sampled on the cycle mul_done=1 in WAIT
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0, all outputs 0. Reset mid-job drops it silently (no rsp).
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs registered.
//   IDLE : if |req at edge: pick winner, latch mul_a/mul_b/owner, -> ISSUE; else stay.
//   ISSUE: gnt[owner]=1, mul_start=1 for exactly this cycle; clear watchdog; -> WAIT.
//   WAIT : mul_done=1 at edge -> latch mul_result into rsp_data, -> RESP.
//          Else watchdog+1; when it reaches TIMEOUT -> rsp_data=0, rsp_err=1, -> RESP.
//          mul_done and timeout on the same edge: done wins, no error.
//   RESP : rsp_valid[owner]=1 (rsp_err as set) for one cycle; -> IDLE.
//  Latency: req seen at edge t -> gnt/mul_start in cycle t+1; done seen at edge w ->
//   rsp_valid in cycle w+1; earliest re-grant edge is w+2 (one idle cycle between jobs).
//  Round-robin: search starts at pointer p, wraps at NREQ-1 -> 0; after granting i,
//   p = (i+1) mod NREQ. Aborted jobs advance p the same way.
//  req is ignored outside IDLE; requester must drop or re-present req after gnt.
//  mul_done high in ISSUE or IDLE is ignored (stale done from previous job).
//  Product width: 16-bit, unsigned, passed through unmodified; no truncation.
//  No requester is starved: each waits at most NREQ-1 jobs after first seen by IDLE.
// TESTING
//  1 Reset: hold rst 2 cycles mid-WAIT -> IDLE, gnt/rsp_valid/mul_start/busy=0, no rsp.
//  2 Single: req[0], a=8'hFF, b=8'hFF; model done 4 cyc after start -> rsp_valid=2'b01,
//    rsp_data=16'hFE01, rsp_err=0, rsp 1 cycle after done.
//  3 Contention: req=2'b11 const, a0=3,b0=5,a1=7,b1=9 -> grants 0,1,0,1; results 15,63.
//  4 Fairness: after job for req1, assert both -> req0 wins; pointer wraps correctly.
//  5 Timeout: never assert mul_done -> rsp_err=1, rsp_data=0 exactly TIMEOUT WAIT cycles in.
//  6 Edge: mul_done on last WAIT cycle -> normal rsp; stale mul_done in IDLE -> ignored.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that shares one sequential 8x8 multiplier among NREQ requesters.
// A granted job latches its operands, pulses mul_start, waits for mul_done (bounded by a
// watchdog) and returns the 16-bit product, or an error response on abort, to its owner.
module mult_share_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned IDW     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] a_in,
    input  logic [NREQ*8-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic              rsp_err,
    output logic [15:0]       rsp_data,
    output logic              busy,
    output logic [IDW-1:0]    owner,
    output logic              mul_start,
    output logic [7:0]        mul_a,
    output logic [7:0]        mul_b,
    input  logic              mul_done,
    input  logic [15:0]       mul_result
);

    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state_q;
    logic [IDW-1:0]  ptr_q;
    logic [WDW-1:0]  wd_q;

    logic            win_found;
    logic [IDW-1:0]  win_id;
    logic [IDW-1:0]  ptr_next;
    logic [NREQ-1:0] win_oh;
    logic [NREQ-1:0] own_oh;
    logic [7:0]      sel_a;
    logic [7:0]      sel_b;

    // Round-robin pick: first requester at or above the pointer, else lowest overall.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!win_found && req[i] && (i >= 32'(ptr_q))) begin
                win_found = 1'b1;
                win_id    = IDW'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!win_found && req[i]) begin
                win_found = 1'b1;
                win_id    = IDW'(i);
            end
        end
        ptr_next = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
    end

    // Operand mux and one-hot encodings for the winner and the current owner.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        win_oh = '0;
        own_oh = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_id == IDW'(i)) begin
                sel_a     = a_in[8*i +: 8];
                sel_b     = b_in[8*i +: 8];
                win_oh[i] = 1'b1;
            end
            own_oh[i] = (owner == IDW'(i));
        end
    end

    // Job sequencer; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            wd_q      <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            owner     <= '0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (win_found) begin
                        state_q   <= StIssue;
                        owner     <= win_id;
                        mul_a     <= sel_a;
                        mul_b     <= sel_b;
                        gnt       <= win_oh;
                        mul_start <= 1'b1;
                        busy      <= 1'b1;
                        ptr_q     <= ptr_next;
                    end
                end
                StIssue: begin
                    gnt       <= '0;
                    mul_start <= 1'b0;
                    wd_q      <= '0;
                    state_q   <= StWait;
                end
                StWait: begin
                    // Done takes priority over a watchdog expiring on the same edge.
                    if (mul_done) begin
                        rsp_data  <= mul_result;
                        rsp_err   <= 1'b0;
                        rsp_valid <= own_oh;
                        state_q   <= StResp;
                    end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= own_oh;
                        state_q   <= StResp;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                StResp: begin
                    rsp_valid <= '0;
                    rsp_err   <= 1'b0;
                    busy      <= 1'b0;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: directed scenarios plus randomized jobs,
// checked against a behavioural round-robin / multiplier model.
module tb_mult_share_arbiter;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 15;
    localparam int IDW     = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*8-1:0] a_in;
    logic [NREQ*8-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic              rsp_err;
    logic [15:0]       rsp_data;
    logic              busy;
    logic [IDW-1:0]    owner;
    logic              mul_start;
    logic [7:0]        mul_a;
    logic [7:0]        mul_b;
    logic              mul_done;
    logic [15:0]       mul_result;

    int checks   = 0;
    int failures = 0;
    int rr       = 0;
    logic [7:0]  op_a [NREQ];
    logic [7:0]  op_b [NREQ];
    logic [15:0] last_data = '0;

    mult_share_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .a_in       (a_in),
        .b_in       (b_in),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .owner      (owner),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        op_a[i]         = a;
        op_b[i]         = b;
        a_in[8*i +: 8]  = a;
        b_in[8*i +: 8]  = b;
    endtask

    // Model: scan from the pointer upward with wrap, first active request wins.
    function automatic int model_pick(input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    // Entered and left in an IDLE cycle, #1 after the edge. done_after is the WAIT cycle
    // (1-based) in which the modelled multiplier raises mul_done; outside 1..TIMEOUT = never.
    task automatic do_job(input string name, input int exp_win, input int done_after,
                          input bit drop, input bit stale_issue);
        logic [7:0]      ea, eb;
        logic [15:0]     prod, exp_data;
        logic [NREQ-1:0] oh;
        bit              exp_err, hit;
        ea       = op_a[exp_win];
        eb       = op_b[exp_win];
        prod     = {8'h00, ea} * {8'h00, eb};
        oh       = '0;
        oh[exp_win] = 1'b1;
        exp_err  = (done_after < 1) || (done_after > TIMEOUT);
        exp_data = exp_err ? 16'h0000 : prod;
        rr       = (exp_win + 1) % NREQ;

        step();
        checks++;
        if (gnt !== oh || mul_start !== 1'b1 || busy !== 1'b1)
            $display("FAIL %s grant: gnt=%b start=%b busy=%b, expected gnt=%b start=1 busy=1",
                     name, gnt, mul_start, busy, oh);
        if (gnt !== oh || mul_start !== 1'b1 || busy !== 1'b1) failures++;
        checks++;
        if (owner !== IDW'(exp_win) || mul_a !== ea || mul_b !== eb) begin
            failures++;
            $display("FAIL %s latch: owner=%0d a=%h b=%h, expected owner=%0d a=%h b=%h",
                     name, owner, mul_a, mul_b, exp_win, ea, eb);
        end
        if (drop) req[exp_win] = 1'b0;
        if (stale_issue) begin
            mul_done   = 1'b1;
            mul_result = 16'($urandom);
        end
        step();
        mul_done = 1'b0;

        hit = 1'b0;
        for (int c = 1; c <= TIMEOUT && !hit; c++) begin
            checks++;
            if (gnt !== '0 || mul_start !== 1'b0 || rsp_valid !== '0 || busy !== 1'b1 ||
                mul_a !== ea || mul_b !== eb) begin
                failures++;
                $display("FAIL %s wait%0d: gnt=%b start=%b rv=%b busy=%b a=%h b=%h, expected 0 0 0 1 %h %h",
                         name, c, gnt, mul_start, rsp_valid, busy, mul_a, mul_b, ea, eb);
            end
            if (c == done_after) begin
                mul_done   = 1'b1;
                mul_result = prod;
                hit        = 1'b1;
            end
            step();
            mul_done = 1'b0;
        end

        checks++;
        if (rsp_valid !== oh || rsp_err !== exp_err || rsp_data !== exp_data || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s resp: rv=%b err=%b data=%h busy=%b, expected rv=%b err=%b data=%h busy=1",
                     name, rsp_valid, rsp_err, rsp_data, busy, oh, exp_err, exp_data);
        end
        step();
        checks++;
        if (rsp_valid !== '0 || rsp_err !== 1'b0 || rsp_data !== exp_data || busy !== 1'b0 ||
            gnt !== '0) begin
            failures++;
            $display("FAIL %s idle: rv=%b err=%b data=%h busy=%b gnt=%b, expected 0 0 %h 0 0",
                     name, rsp_valid, rsp_err, rsp_data, busy, gnt, exp_data);
        end
        last_data = exp_data;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (gnt !== '0 || rsp_valid !== '0 || rsp_err !== 1'b0 || rsp_data !== '0 ||
            busy !== 1'b0 || owner !== '0 || mul_start !== 1'b0 || mul_a !== '0 || mul_b !== '0) begin
            failures++;
            $display("FAIL %s: gnt=%b rv=%b err=%b data=%h busy=%b own=%0d start=%b a=%h b=%h, expected all 0",
                     name, gnt, rsp_valid, rsp_err, rsp_data, busy, owner, mul_start, mul_a, mul_b);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        rr        = 0;
        last_data = '0;
    endtask

    task automatic test_reset();
        req = '0; mul_done = 1'b0; mul_result = '0;
        for (int i = 0; i < NREQ; i++) set_ops(i, 8'h00, 8'h00);
        apply_reset();
        check_zero("reset_state");
        // Start a job, then reset in the middle of WAIT.
        set_ops(0, 8'h12, 8'h34);
        req = 2'b01;
        step();
        req = '0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        check_zero("reset_mid_wait_1");
        step();
        check_zero("reset_mid_wait_2");
        rst = 1'b0;
        rr  = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (rsp_valid !== '0 || busy !== 1'b0 || gnt !== '0) begin
                failures++;
                $display("FAIL reset_no_rsp: rv=%b busy=%b gnt=%b, expected 0 0 0",
                         rsp_valid, busy, gnt);
            end
        end
    endtask

    task automatic test_single();
        set_ops(0, 8'hFF, 8'hFF);
        req = 2'b01;
        do_job("single", 0, 4, 1'b1, 1'b0);
        checks++;
        if (rsp_data !== 16'hFE01) begin
            failures++;
            $display("FAIL single_product: data=%h, expected fe01", rsp_data);
        end
    endtask

    task automatic test_fairness();
        apply_reset();
        set_ops(1, 8'h0B, 8'h0D);
        req = 2'b10;
        do_job("fair_r1", 1, 3, 1'b1, 1'b0);
        set_ops(0, 8'h02, 8'h21);
        set_ops(1, 8'h11, 8'h05);
        req = 2'b11;
        do_job("fair_r0", 0, 2, 1'b0, 1'b0);
        do_job("fair_wrap", 1, 5, 1'b0, 1'b0);
        req = '0;
    endtask

    task automatic test_contention();
        int exp_seq [4] = '{0, 1, 0, 1};
        logic [15:0] exp_prod [4] = '{16'd15, 16'd63, 16'd15, 16'd63};
        apply_reset();
        set_ops(0, 8'd3, 8'd5);
        set_ops(1, 8'd7, 8'd9);
        req = 2'b11;
        for (int j = 0; j < 4; j++) begin
            do_job("contention", exp_seq[j], 4, 1'b0, 1'b0);
            checks++;
            if (rsp_data !== exp_prod[j]) begin
                failures++;
                $display("FAIL contention_product%0d: data=%0d, expected %0d", j, rsp_data, exp_prod[j]);
            end
        end
        req = '0;
    endtask

    task automatic test_timeout();
        set_ops(0, 8'hA5, 8'h5A);
        req = 2'b01;
        do_job("timeout", model_pick(req), 0, 1'b1, 1'b0);
    endtask

    task automatic test_edge();
        set_ops(1, 8'hC3, 8'h7E);
        req = 2'b10;
        do_job("done_last_cycle", model_pick(req), TIMEOUT, 1'b1, 1'b0);
        // Stale done while idle must not start or answer anything.
        req        = '0;
        mul_done   = 1'b1;
        mul_result = 16'hDEAD;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (busy !== 1'b0 || rsp_valid !== '0 || rsp_data !== last_data) begin
                failures++;
                $display("FAIL stale_idle: busy=%b rv=%b data=%h, expected 0 0 %h",
                         busy, rsp_valid, rsp_data, last_data);
            end
        end
        mul_done = 1'b0;
        set_ops(0, 8'h10, 8'h10);
        req = 2'b01;
        do_job("stale_issue", model_pick(req), 3, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        int w;
        for (int j = 0; j < 40; j++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    req[i] = 1'b1;
                    set_ops(i, 8'($urandom), 8'($urandom));
                end
            end
            if (req == '0) begin
                w = $urandom_range(0, NREQ - 1);
                req[w] = 1'b1;
                set_ops(w, 8'($urandom), 8'($urandom));
            end
            do_job("random", model_pick(req), $urandom_range(1, TIMEOUT + 2),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end
        req = '0;
    endtask

    initial begin
        a_in = '0;
        b_in = '0;
        rst  = 1'b1;
        test_reset();
        test_single();
        test_fairness();
        test_contention();
        test_timeout();
        test_edge();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

endmodule
